// File: rtl/sr_cmd_gen_debounce_edge.sv
// One button channel: 2-flop synchroniser, stability-count debouncer and
// registered rising-edge pulse on the debounced level.
module debounce_edge #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic db,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] dcnt;
  logic          accept;

  // The new level is taken on the edge that completes the stable run.
  assign accept = (sync2 != db) && ((int'(dcnt) + 1) >= DEBOUNCE_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dcnt  <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == db) begin
        dcnt <= '0;
      end else if (accept) begin
        db   <= sync2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
      rise <= accept & sync2;
    end
  end

endmodule

// File: rtl/sr_cmd_gen.sv
// Button-to-SR command stage: two debounced channels feed a registered
// arbiter that never drives s and r together, plus saturating press counters.
module sr_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_set,
  input  logic             btn_rst,
  output logic             s,
  output logic             r,
  output logic             conflict,
  output logic [CNT_W-1:0] set_count,
  output logic [CNT_W-1:0] rst_count
);

  logic rise_set_p0;
  logic rise_rst_p0;
  logic issue_set;
  logic issue_rst;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_set),
    .db   (),
    .rise (rise_set_p0)
  );

  debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_rst),
    .db   (),
    .rise (rise_rst_p0)
  );

  assign issue_set = rise_set_p0 & ~rise_rst_p0;
  assign issue_rst = rise_rst_p0 & ~rise_set_p0;

  // Arbiter stage: simultaneous presses are dropped and flagged, not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= 1'b0;
      r         <= 1'b0;
      conflict  <= 1'b0;
      set_count <= '0;
      rst_count <= '0;
    end else begin
      s        <= issue_set;
      r        <= issue_rst;
      conflict <= rise_set_p0 & rise_rst_p0;
      if (issue_set) set_count <= sat_inc(set_count);
      if (issue_rst) rst_count <= sat_inc(rst_count);
    end
  end

endmodule
